// File: rtl/priority_encoder_rr.sv
// Registered N-way priority encoder, fixed-MSB or round-robin; optional grant counter under PRIORITY_ENC_STAT_EN.
// Latency: 1 cycle from req sampled to valid/out/gnt visible; back-to-back grants on handshake with no bubble.
// Backpressure: a grant is held frozen until ack while valid; req is not re-evaluated until then.
module priority_encoder_rr #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] out,
    output logic [N-1:0] gnt,
    output logic         valid
`ifdef PRIORITY_ENC_STAT_EN
    ,
    output logic [15:0]  grant_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_nxt;
    logic [W-1:0]   out_nxt;
    logic [W-1:0]   win;
    logic [N-1:0]   gnt_nxt;
    logic           hs;
    logic           any_req;

    function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] r);
        logic [W-1:0] sel;
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) sel = W'(i);
        end
        return sel;
    endfunction

    // Walk downward from start with an explicit wrap so non-power-of-two N works.
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] r, input logic [W-1:0] start);
        logic [W-1:0] cand;
        logic [W-1:0] sel;
        logic         found;
        cand  = start;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = (cand == '0) ? LAST : cand - ONE;
        end
        return sel;
    endfunction

    assign valid = (state == GRANT);

    always_comb begin
        hs        = valid & ack;
        any_req   = |req;
        ptr_nxt   = ptr;
        state_nxt = state;
        out_nxt   = out;
        gnt_nxt   = gnt;

        // The pointer moves on handshake, and a back-to-back winner already sees the moved value.
        if (hs) begin
            ptr_nxt = (out == '0) ? LAST : out - ONE;
        end

        if (MODE == 0) begin
            win = pick_fixed(req);
        end else begin
            win = pick_rr(req, ptr_nxt);
        end

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt    = GRANT;
                    out_nxt      = win;
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                end
            end
            GRANT: begin
                if (hs) begin
                    if (any_req) begin
                        out_nxt      = win;
                        gnt_nxt      = '0;
                        gnt_nxt[win] = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        out_nxt   = '0;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                out_nxt   = '0;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            gnt   <= '0;
            ptr   <= LAST;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef PRIORITY_ENC_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (hs && (grant_cnt != 16'hFFFF)) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: three instances (N=8 fixed, N=8 round-robin, N=5 round-robin) against a modulo-arithmetic model.
module tb_priority_encoder_rr;

    logic       clk;
    logic       rst_n;
    logic [7:0] r_in [3];
    logic       a_in [3];

    logic [7:0] req0;
    logic [7:0] req1;
    logic [4:0] req2;
    logic       ack0, ack1, ack2;
    logic [2:0] out0, out1, out2;
    logic [7:0] gnt0, gnt1;
    logic [4:0] gnt2;
    logic       valid0, valid1, valid2;
`ifdef PRIORITY_ENC_STAT_EN
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    assign req0 = r_in[0];
    assign req1 = r_in[1];
    assign req2 = r_in[2][4:0];
    assign ack0 = a_in[0];
    assign ack1 = a_in[1];
    assign ack2 = a_in[2];

    priority_encoder_rr #(.N(8), .MODE(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .req(req0), .ack(ack0),
        .out(out0), .gnt(gnt0), .valid(valid0)
`ifdef PRIORITY_ENC_STAT_EN
        , .grant_cnt(cnt0)
`endif
    );

    priority_encoder_rr #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1),
        .out(out1), .gnt(gnt1), .valid(valid1)
`ifdef PRIORITY_ENC_STAT_EN
        , .grant_cnt(cnt1)
`endif
    );

    priority_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req2), .ack(ack2),
        .out(out2), .gnt(gnt2), .valid(valid2)
`ifdef PRIORITY_ENC_STAT_EN
        , .grant_cnt(cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int NS [3] = '{8, 8, 5};
    int MS [3] = '{0, 1, 1};
    int m_valid [3];
    int m_out   [3];
    int m_ptr   [3];
    int m_cnt   [3];

    function automatic int pick(int n, int mode, int ptr, logic [7:0] r);
        int idx;
        if (mode == 0) begin
            for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < n; k++) begin
                idx = (ptr - k + n) % n;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int n, w;
        bit hs;
        for (int d = 0; d < 3; d++) begin
            n = NS[d];
            if (!rst_n) begin
                m_valid[d] = 0; m_out[d] = 0; m_ptr[d] = n - 1; m_cnt[d] = 0;
            end else begin
                hs = (m_valid[d] != 0) && a_in[d];
                if (hs) begin
                    m_ptr[d] = (m_out[d] + n - 1) % n;
                    if (m_cnt[d] < 65535) m_cnt[d]++;
                end
                if (m_valid[d] == 0 || hs) begin
                    w = pick(n, MS[d], m_ptr[d], r_in[d]);
                    if (w >= 0) begin
                        m_valid[d] = 1; m_out[d] = w;
                    end else begin
                        m_valid[d] = 0; m_out[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [7:0]  o, g, eg;
        logic        v;
        logic [15:0] c;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0:       begin o = {5'd0, out0}; g = gnt0;         v = valid0; end
                1:       begin o = {5'd0, out1}; g = gnt1;         v = valid1; end
                default: begin o = {5'd0, out2}; g = {3'd0, gnt2}; v = valid2; end
            endcase
            eg = (m_valid[d] != 0) ? (8'd1 << m_out[d]) : 8'd0;
            check($sformatf("d%0d_valid", d), 64'(v), 64'(m_valid[d] != 0));
            check($sformatf("d%0d_out", d), 64'(o), 64'(m_out[d]));
            check($sformatf("d%0d_gnt", d), 64'(g), 64'(eg));
`ifdef PRIORITY_ENC_STAT_EN
            case (d)
                0:       c = cnt0;
                1:       c = cnt1;
                default: c = cnt2;
            endcase
            check($sformatf("d%0d_cnt", d), 64'(c), 64'(m_cnt[d]));
`else
            c = 16'd0;
`endif
        end
    endtask

    task automatic step(input bit chk);
        model_edge();
        @(posedge clk);
        #1;
        if (chk) check_all();
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) begin
            r_in[d] = 8'd0; a_in[d] = 1'b0;
        end
    endtask

    int seq [6] = '{7, 3, 0, 7, 3, 0};

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        step(1); step(1);

        // quiet after reset
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("quiet_valid", 64'(valid0 | valid1 | valid2), 64'd0);
        end

        // fixed priority, grant frozen while unacked
        r_in[0] = 8'b0101_0010;
        step(1);
        check("fix_out6", 64'(out0), 64'd6);
        check("fix_gnt6", 64'(gnt0), 64'h40);
        r_in[0] = 8'b0000_0001;
        step(1); step(1);
        check("fix_frozen", 64'(out0), 64'd6);
        a_in[0] = 1'b1;
        step(1);
        check("fix_b2b_out0", 64'(out0), 64'd0);
        check("fix_b2b_valid", 64'(valid0), 64'd1);
        r_in[0] = 8'd0;
        step(1);
        check("fix_to_idle", 64'(valid0), 64'd0);
        a_in[0] = 1'b0;

        // round-robin rotation with ack held high
        r_in[1] = 8'b1000_1001;
        a_in[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("rr_seq%0d", i), 64'(out1), 64'(seq[i]));
            check($sformatf("rr_seq_valid%0d", i), 64'(valid1), 64'd1);
        end
        r_in[1] = 8'd0;
        step(1);
        a_in[1] = 1'b0;

        // N=5 wrap
        r_in[2] = 8'b0000_0001;
        step(1);
        check("n5_first", 64'(out2), 64'd0);
        r_in[2] = 8'd0; a_in[2] = 1'b1;
        step(1);
        check("n5_idle", 64'(valid2), 64'd0);
        r_in[2] = 8'b0001_0001; a_in[2] = 1'b0;
        step(1);
        check("n5_wrap4", 64'(out2), 64'd4);
        a_in[2] = 1'b1;
        step(1);
        check("n5_next0", 64'(out2), 64'd0);
        check("n5_next_valid", 64'(valid2), 64'd1);
        idle_inputs();
        step(1);

        // reset mid-grant restores the pointer
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        r_in[1] = 8'b0000_1000;
        step(1);
        check("rst_pre3", 64'(out1), 64'd3);
        r_in[1] = 8'b0010_0000; a_in[1] = 1'b1;
        step(1);
        check("rst_pre5", 64'(out1), 64'd5);
        rst_n = 1'b0;
        step(1);
        check("rst_mid_valid", 64'(valid1), 64'd0);
        check("rst_mid_out", 64'(out1), 64'd0);
        check("rst_mid_gnt", 64'(gnt1), 64'd0);
        rst_n = 1'b1; a_in[1] = 1'b0;
        r_in[1] = 8'b0010_0100;
        step(1);
        check("rst_ptr_restored", 64'(out1), 64'd5);
        idle_inputs();
        step(1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                r_in[d] = 8'($urandom) & ((d == 2) ? 8'h1F : 8'hFF);
                if ($urandom_range(0, 3) == 0) r_in[d] = 8'd0;
                a_in[d] = 1'($urandom);
            end
            rst_n = ($urandom_range(0, 63) != 0);
            step(1);
        end
        rst_n = 1'b1;
        idle_inputs();
        step(1);

`ifdef PRIORITY_ENC_STAT_EN
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        r_in[0] = 8'h01;
        step(1);
        a_in[0] = 1'b1;
        step(1); step(1);
        r_in[0] = 8'd0;
        step(1);
        step(1); step(1);
        check("cnt_three", 64'(cnt0), 64'd3);
        a_in[0] = 1'b0;
        r_in[0] = 8'hFF; a_in[0] = 1'b1;
        for (int i = 0; i < 65540; i++) step(0);
        check("cnt_sat", 64'(cnt0), 64'hFFFF);
        step(1);
        check("cnt_sat_hold", 64'(cnt0), 64'hFFFF);
        idle_inputs();
        step(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
